// File: rtl/reg_wb_if.sv
// Writeback request bundle for reg_wb_arbiter: main result, R7 link and R6 stack-pointer
// request/ack handshakes with their data. The master drives requests, the slave returns acks.
interface reg_wb_if #(
  parameter int DATA_W = 16
);
  logic              main_req;
  logic [2:0]        main_ir11to9;
  logic [DATA_W-1:0] main_data;
  logic              main_ack;
  logic              link_req;
  logic [DATA_W-1:0] link_data;
  logic              link_ack;
  logic              sp_req;
  logic [DATA_W-1:0] sp_data;
  logic              sp_ack;

  modport master (
    output main_req, main_ir11to9, main_data,
    output link_req, link_data,
    output sp_req, sp_data,
    input  main_ack, link_ack, sp_ack
  );

  modport slave (
    input  main_req, main_ir11to9, main_data,
    input  link_req, link_data,
    input  sp_req, sp_data,
    output main_ack, link_ack, sp_ack
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// LC-3 register-file write-port arbiter: three one-entry slots (main, R7 link, R6 SP), one write per cycle.
// Build option REG_WB_RR_EN: rotating main->link->sp priority instead of fixed sp>link>main with main aging.
module reg_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_wb_if.slave           bus,
  output logic              wr_en,
  output logic [1:0]        drmux_sel,
  output logic [2:0]        wr_dr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);
  localparam logic [1:0] SEL_MAIN = 2'b00;
  localparam logic [1:0] SEL_LINK = 2'b01;
  localparam logic [1:0] SEL_SP   = 2'b10;

  logic              main_v_q, main_v_d, link_v_q, link_v_d, sp_v_q, sp_v_d;
  logic [2:0]        main_dr_q, main_dr_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, link_data_q, link_data_d, sp_data_q, sp_data_d;
  logic              wr_en_q, wr_en_d;
  logic [1:0]        sel_q, sel_d;
  logic [2:0]        dr_q, dr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt_main, gnt_link, gnt_sp;
  logic              main_ack, link_ack, sp_ack;

`ifdef REG_WB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_main = 1'b0;
    gnt_link = 1'b0;
    gnt_sp   = 1'b0;
    case (rr_ptr_q)
      SEL_LINK: begin
        if (link_v_q)      gnt_link = 1'b1;
        else if (sp_v_q)   gnt_sp   = 1'b1;
        else if (main_v_q) gnt_main = 1'b1;
      end
      SEL_SP: begin
        if (sp_v_q)        gnt_sp   = 1'b1;
        else if (main_v_q) gnt_main = 1'b1;
        else if (link_v_q) gnt_link = 1'b1;
      end
      default: begin
        if (main_v_q)      gnt_main = 1'b1;
        else if (link_v_q) gnt_link = 1'b1;
        else if (sp_v_q)   gnt_sp   = 1'b1;
      end
    endcase
  end

  // Pointer moves to the source following the one just granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_main)      rr_ptr_d = SEL_LINK;
    else if (gnt_link) rr_ptr_d = SEL_SP;
    else if (gnt_sp)   rr_ptr_d = SEL_MAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= SEL_MAIN;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] main_age_q, main_age_d;

  always_comb begin
    gnt_main = 1'b0;
    gnt_link = 1'b0;
    gnt_sp   = 1'b0;
    if (main_v_q && (main_age_q >= MAX_WAIT_C)) gnt_main = 1'b1;
    else if (sp_v_q)                            gnt_sp   = 1'b1;
    else if (link_v_q)                          gnt_link = 1'b1;
    else if (main_v_q)                          gnt_main = 1'b1;
  end

  // Age counts only cycles where main waits behind another grant; saturates at 15
  always_comb begin
    main_age_d = main_age_q;
    if (!main_v_q || gnt_main)   main_age_d = 4'd0;
    else if (main_age_q != 4'hf) main_age_d = main_age_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) main_age_q <= 4'd0;
    else        main_age_q <= main_age_d;
  end
`endif

  // Ack is a function of slot state and grant only, never of the same source's req
  assign main_ack = !main_v_q || gnt_main;
  assign link_ack = !link_v_q || gnt_link;
  assign sp_ack   = !sp_v_q   || gnt_sp;

  assign bus.main_ack = main_ack;
  assign bus.link_ack = link_ack;
  assign bus.sp_ack   = sp_ack;

  // A refill in the grant cycle wins over the drain, so the slot stays valid
  always_comb begin
    main_v_d    = main_v_q;
    main_dr_d   = main_dr_q;
    main_data_d = main_data_q;
    link_v_d    = link_v_q;
    link_data_d = link_data_q;
    sp_v_d      = sp_v_q;
    sp_data_d   = sp_data_q;
    if (bus.main_req && main_ack) begin
      main_v_d    = 1'b1;
      main_dr_d   = bus.main_ir11to9;
      main_data_d = bus.main_data;
    end else if (gnt_main) begin
      main_v_d = 1'b0;
    end
    if (bus.link_req && link_ack) begin
      link_v_d    = 1'b1;
      link_data_d = bus.link_data;
    end else if (gnt_link) begin
      link_v_d = 1'b0;
    end
    if (bus.sp_req && sp_ack) begin
      sp_v_d    = 1'b1;
      sp_data_d = bus.sp_data;
    end else if (gnt_sp) begin
      sp_v_d = 1'b0;
    end
  end

  always_comb begin
    wr_en_d = gnt_main || gnt_link || gnt_sp;
    sel_d   = sel_q;
    dr_d    = dr_q;
    wdata_d = wdata_q;
    if (gnt_sp) begin
      sel_d   = SEL_SP;
      dr_d    = 3'b110;
      wdata_d = sp_data_q;
    end else if (gnt_link) begin
      sel_d   = SEL_LINK;
      dr_d    = 3'b111;
      wdata_d = link_data_q;
    end else if (gnt_main) begin
      sel_d   = SEL_MAIN;
      dr_d    = main_dr_q;
      wdata_d = main_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      link_v_q <= 1'b0;
      sp_v_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      sel_q    <= SEL_MAIN;
      dr_q     <= 3'b000;
      wdata_q  <= '0;
    end else begin
      main_v_q <= main_v_d;
      link_v_q <= link_v_d;
      sp_v_q   <= sp_v_d;
      wr_en_q  <= wr_en_d;
      sel_q    <= sel_d;
      dr_q     <= dr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    main_dr_q   <= main_dr_d;
    main_data_q <= main_data_d;
    link_data_q <= link_data_d;
    sp_data_q   <= sp_data_d;
  end

  assign wr_en     = wr_en_q;
  assign drmux_sel = sel_q;
  assign wr_dr     = dr_q;
  assign wr_data   = wdata_q;
  assign busy      = main_v_q || link_v_q || sp_v_q;
endmodule
